ppu_row_writer: RTL and testbench

PPU-side producer for the double-buffered row RAM that the HDMI video output reads.
- Owns both 320-entry banks of 10-bit palette-address words.
- Serves the video output's 1-cycle-latency read port.
- Toggles banks on rowram_swap and fills the back bank from an upstream pixel stream, row by row, paced by the vblank_end_soon, vblank_start and rowram_swap strobes.

---
 rtl/ppu_row_writer_if.sv | 21 ++
 rtl/ppu_row_writer.sv | 168 ++++++++++++++++
 tb/tb_ppu_row_writer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_row_writer_if.sv
// Pixel stream handshake between the upstream pixel source and the row writer.
// master: drives pix_valid/pix_data; slave: drives pix_ready.
interface ppu_row_writer_if #(
  parameter int DATA_W = 10
) ();
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;

  modport master (
    output pix_valid,
    output pix_data,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    output pix_ready
  );
endinterface

// File: rtl/ppu_row_writer.sv
// PPU-side producer for the double-buffered HDMI row RAM. Serves a 1-cycle read
// port from the front bank, fills the back bank row by row from pix_if.
// Ports: video_clk, rst (async, active-high), i_rowram_rdaddr/o_rowram_rddata
// read port, i_rowram_swap/i_vblank_start/i_vblank_end_soon strobes,
// o_row_req/o_row_num row request, pix_if (slave) pixel stream,
// o_underrun sticky flag with i_clr_underrun.
// Optional: ROW_WRITER_UNDERRUN_CNT_EN adds o_underrun_cnt[7:0] (saturating).
module ppu_row_writer #(
  parameter int ROW_WIDTH = 320,
  parameter int NUM_ROWS  = 240,
  parameter int DATA_W    = 10
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic [8:0]        i_rowram_rdaddr,
  output logic [DATA_W-1:0] o_rowram_rddata,
  input  logic              i_rowram_swap,
  input  logic              i_vblank_start,
  input  logic              i_vblank_end_soon,
  output logic              o_row_req,
  output logic [7:0]        o_row_num,
  ppu_row_writer_if.slave   pix_if,
  output logic              o_underrun,
  input  logic              i_clr_underrun
`ifdef ROW_WRITER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]        o_underrun_cnt
`endif
);

  localparam logic [8:0] LP_LAST_PIX = 9'(ROW_WIDTH - 1);
  localparam logic [7:0] LP_LAST_ROW = 8'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [8:0]  r_wr_ptr;
  logic [8:0]  w_wr_ptr_n;
  logic [7:0]  r_row_num;
  logic [7:0]  w_row_num_n;
  logic        r_row_req;
  logic        w_row_req_n;
  logic        r_front;
  logic        w_front_n;
  logic        r_underrun;
  logic        w_under_set;
  logic        w_accept;

  logic [DATA_W-1:0] r_bank [2][ROW_WIDTH];

  assign pix_if.pix_ready = (r_state == S_FILL);
  assign w_accept = (r_state == S_FILL) && pix_if.pix_valid;

  always_comb begin
    w_state_n   = r_state;
    w_wr_ptr_n  = r_wr_ptr;
    w_row_num_n = r_row_num;
    w_row_req_n = 1'b0;
    w_under_set = 1'b0;
    // Swap always exchanges banks, whatever else happens this cycle.
    w_front_n   = r_front ^ i_rowram_swap;
    if (i_vblank_end_soon) begin
      w_state_n   = S_FILL;
      w_wr_ptr_n  = '0;
      w_row_num_n = '0;
      w_row_req_n = 1'b1;
    end else if (i_vblank_start) begin
      w_state_n  = S_IDLE;
      w_wr_ptr_n = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          // A swap mid-row is an underrun; the row keeps filling.
          w_under_set = i_rowram_swap;
          if (w_accept) begin
            if (r_wr_ptr == LP_LAST_PIX) begin
              w_state_n  = S_WAIT;
              w_wr_ptr_n = '0;
            end else begin
              w_wr_ptr_n = r_wr_ptr + 9'd1;
            end
          end
        end
        S_WAIT: begin
          if (i_rowram_swap) begin
            if (r_row_num == LP_LAST_ROW) begin
              w_state_n = S_IDLE;
            end else begin
              w_state_n   = S_FILL;
              w_row_num_n = r_row_num + 8'd1;
              w_row_req_n = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_row_num  <= '0;
      r_row_req  <= 1'b0;
      r_front    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_wr_ptr  <= w_wr_ptr_n;
      r_row_num <= w_row_num_n;
      r_row_req <= w_row_req_n;
      r_front   <= w_front_n;
      if (w_under_set) begin
        r_underrun <= 1'b1;
      end else if (i_clr_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

  // Writes use the pre-swap back bank, so a last pixel coinciding
  // with a swap lands in the bank that becomes front.
  always_ff @(posedge video_clk) begin
    if (w_accept) begin
      r_bank[~r_front][r_wr_ptr] <= pix_if.pix_data;
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      o_rowram_rddata <= '0;
    end else if (i_rowram_rdaddr <= LP_LAST_PIX) begin
      o_rowram_rddata <= r_bank[r_front][i_rowram_rdaddr];
    end else begin
      o_rowram_rddata <= '0;
    end
  end

  assign o_row_req  = r_row_req;
  assign o_row_num  = r_row_num;
  assign o_underrun = r_underrun;

`ifdef ROW_WRITER_UNDERRUN_CNT_EN
  logic [7:0] r_under_cnt;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_under_cnt <= '0;
    end else if (w_under_set) begin
      if (r_under_cnt != 8'hFF) begin
        r_under_cnt <= r_under_cnt + 8'd1;
      end
    end else if (i_clr_underrun) begin
      r_under_cnt <= '0;
    end
  end

  assign o_underrun_cnt = r_under_cnt;
`endif

endmodule

// File: tb/tb_ppu_row_writer.sv
// Randomized self-checking bench for ppu_row_writer with a behavioural
// row-RAM / frame model and hand-computed literal checkpoints.
module tb_ppu_row_writer;

  logic       clk;
  logic       rst;
  logic [8:0] rdaddr;
  logic [9:0] rddata;
  logic       swap;
  logic       vbs;
  logic       ves;
  logic       row_req;
  logic [7:0] row_num;
  logic       under;
  logic       clr;
`ifdef ROW_WRITER_UNDERRUN_CNT_EN
  logic [7:0] ucnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ppu_row_writer_if #(.DATA_W(10)) u_if ();

  ppu_row_writer dut (
    .video_clk         (clk),
    .rst               (rst),
    .i_rowram_rdaddr   (rdaddr),
    .o_rowram_rddata   (rddata),
    .i_rowram_swap     (swap),
    .i_vblank_start    (vbs),
    .i_vblank_end_soon (ves),
    .o_row_req         (row_req),
    .o_row_num         (row_num),
    .pix_if            (u_if.slave),
    .o_underrun        (under),
    .i_clr_underrun    (clr)
`ifdef ROW_WRITER_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt    (ucnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: phase 0=idle 1=filling 2=row done.
  logic [9:0] m_bank [2][320];
  bit         m_val  [2][320];
  int m_phase = 0;
  int m_front = 0;
  int m_wptr  = 0;
  int m_row   = 0;
  int m_req   = 0;
  int m_under = 0;
  int m_cnt   = 0;
  int m_rd    = 0;
  bit m_rd_ok = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc;
    bit ev;
    if (rst) begin
      m_phase = 0; m_front = 0; m_wptr = 0; m_row = 0;
      m_req = 0; m_under = 0; m_cnt = 0; m_rd = 0; m_rd_ok = 1'b1;
      return;
    end
    if (rdaddr >= 9'd320) begin
      m_rd = 0;
      m_rd_ok = 1'b1;
    end else begin
      m_rd = int'(m_bank[m_front][rdaddr]);
      m_rd_ok = m_val[m_front][rdaddr];
    end
    acc = (m_phase == 1) && u_if.pix_valid;
    if (acc) begin
      m_bank[1 - m_front][m_wptr] = u_if.pix_data;
      m_val[1 - m_front][m_wptr] = 1'b1;
    end
    ev = 1'b0;
    m_req = 0;
    if (ves) begin
      m_phase = 1; m_row = 0; m_wptr = 0; m_req = 1;
    end else if (vbs) begin
      m_phase = 0; m_wptr = 0;
    end else if (m_phase == 1) begin
      ev = swap;
      if (acc) begin
        m_wptr = m_wptr + 1;
        if (m_wptr == 320) begin
          m_wptr = 0;
          m_phase = 2;
        end
      end
    end else if (m_phase == 2 && swap) begin
      if (m_row == 239) begin
        m_phase = 0;
      end else begin
        m_row = m_row + 1;
        m_phase = 1;
        m_req = 1;
      end
    end
    if (swap) m_front = 1 - m_front;
    if (ev) begin
      m_under = 1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (clr) begin
      m_under = 0;
      m_cnt = 0;
    end
  endtask

  task automatic compare();
    if (m_rd_ok) chk("rddata", int'(rddata), m_rd);
    chk("row_req", int'(row_req), m_req);
    chk("row_num", int'(row_num), m_row);
    chk("pix_ready", int'(u_if.pix_ready), int'(m_phase == 1));
    chk("underrun", int'(under), m_under);
`ifdef ROW_WRITER_UNDERRUN_CNT_EN
    chk("underrun_cnt", int'(ucnt), m_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic pulse_ves();
    ves = 1'b1; tick(); ves = 1'b0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1; tick(); swap = 1'b0;
  endtask

  // Sends n pixels; data is the pixel index unless rnd is set.
  task automatic stream(input int n, input bit rnd, input bit gaps);
    int sent;
    int cyc;
    bit hs;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 4000) begin
      u_if.pix_valid = gaps ? ($urandom_range(0, 31) != 0) : 1'b1;
      u_if.pix_data = rnd ? 10'($urandom) : 10'(sent);
      rdaddr = 9'($urandom);
      hs = u_if.pix_valid && u_if.pix_ready;
      tick();
      if (hs) sent++;
      cyc++;
    end
    u_if.pix_valid = 1'b0;
    if (sent < n) chk("stream_timeout", sent, n);
  endtask

  initial begin
    int idle;
    rst = 1'b1; rdaddr = 9'd5; swap = 1'b0; vbs = 1'b0;
    ves = 1'b0; clr = 1'b0;
    u_if.pix_valid = 1'b0; u_if.pix_data = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 320; j++) m_val[i][j] = 1'b0;
    end

    // Reset with inputs toggling
    for (int i = 0; i < 6; i++) begin
      swap = 1'($urandom); vbs = 1'($urandom); ves = 1'($urandom);
      clr = 1'($urandom); u_if.pix_valid = 1'($urandom);
      u_if.pix_data = 10'($urandom);
      tick();
    end
    chk("rst_rddata", int'(rddata), 0);
    chk("rst_row_req", int'(row_req), 0);
    chk("rst_row_num", int'(row_num), 0);
    chk("rst_ready", int'(u_if.pix_ready), 0);
    chk("rst_underrun", int'(under), 0);
    rst = 1'b0; swap = 1'b0; vbs = 1'b0; ves = 1'b0; clr = 1'b0;
    u_if.pix_valid = 1'b0;
    tick();

    // Nominal fill and read
    pulse_ves();
    chk("nom_req", int'(row_req), 1);
    chk("nom_row", int'(row_num), 0);
    stream(320, 1'b0, 1'b0);
    chk("nom_wait_ready", int'(u_if.pix_ready), 0);
    pulse_swap();
    rdaddr = 9'd0; tick(); chk("nom_rd0", int'(rddata), 0);
    rdaddr = 9'd1; tick(); chk("nom_rd1", int'(rddata), 1);
    rdaddr = 9'd319; tick(); chk("nom_rd319", int'(rddata), 319);
    rdaddr = 9'd400; tick(); chk("nom_rd400", int'(rddata), 0);

    // Full frame
    pulse_ves();
    for (int r = 0; r < 240; r++) begin
      chk("frame_req", int'(row_req), 1);
      chk("frame_row", int'(row_num), r);
      stream(320, 1'b1, 1'b1);
      idle = $urandom_range(1, 2);
      for (int k = 0; k < idle; k++) tick();
      pulse_swap();
    end
    for (int k = 0; k < 4; k++) begin
      chk("frame_end_req", int'(row_req), 0);
      chk("frame_end_ready", int'(u_if.pix_ready), 0);
      tick();
    end
    chk("frame_underrun", int'(under), 0);

    // Underrun mid-row
    pulse_ves();
    stream(100, 1'b0, 1'b0);
    pulse_swap();
    chk("ur_flag", int'(under), 1);
    chk("ur_still_fill", int'(u_if.pix_ready), 1);
    stream(220, 1'b0, 1'b0);
    chk("ur_wait", int'(u_if.pix_ready), 0);
`ifdef ROW_WRITER_UNDERRUN_CNT_EN
    chk("ur_cnt", int'(ucnt), 1);
`endif
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ur_clr", int'(under), 0);

    // Abort on vblank_start in row 7
    pulse_ves();
    for (int r = 0; r < 7; r++) begin
      stream(320, 1'b1, 1'b0);
      pulse_swap();
    end
    chk("ab_row7", int'(row_num), 7);
    stream(50, 1'b1, 1'b0);
    vbs = 1'b1; tick(); vbs = 1'b0;
    chk("ab_ready", int'(u_if.pix_ready), 0);
    chk("ab_row_kept", int'(row_num), 7);
    pulse_ves();
    chk("ab_req", int'(row_req), 1);
    chk("ab_row0", int'(row_num), 0);

    // vblank_start with swap while waiting
    stream(320, 1'b0, 1'b0);
    swap = 1'b1; vbs = 1'b1; tick(); swap = 1'b0; vbs = 1'b0;
    chk("sim_ready", int'(u_if.pix_ready), 0);
    chk("sim_req", int'(row_req), 0);
    rdaddr = 9'd3; tick();
    chk("sim_front", int'(rddata), 3);
    chk("sim_idle", int'(u_if.pix_ready), 0);

    // Last pixel together with swap
    pulse_ves();
    stream(319, 1'b0, 1'b0);
    u_if.pix_valid = 1'b1; u_if.pix_data = 10'h2AB; swap = 1'b1;
    tick();
    u_if.pix_valid = 1'b0; swap = 1'b0;
    chk("lp_underrun", int'(under), 1);
    chk("lp_wait", int'(u_if.pix_ready), 0);
    rdaddr = 9'd319; tick();
    chk("lp_rd319", int'(rddata), 'h2AB);

    // Reset mid-fill
    pulse_ves();
    stream(10, 1'b1, 1'b0);
    rst = 1'b1; tick();
    chk("mr_ready", int'(u_if.pix_ready), 0);
    chk("mr_underrun", int'(under), 0);
    chk("mr_rddata", int'(rddata), 0);
    rst = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
